// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types and constants for the RISC-V pipeline front end.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic [1:0] {FETCH, HOLD, DISCARD} fetch_state_t;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [31:0]     instr;
    logic            valid;
  } if_id_t;
  localparam if_id_t IF_ID_RST = '{pc: '0, pc4: 32'd4, instr: NOP_INSTR, valid: 1'b0};
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with load, flush-to-bubble and hold.
module if_id_reg
  import riscv_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q
);
  // A bubble keeps the old pc so downstream hazard logic sees a stable address.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= IF_ID_RST;
    else if (flush) q <= '{pc: q.pc, pc4: q.pc4, instr: NOP_INSTR, valid: 1'b0};
    else if (load) q <= d;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: IF stage owning the PC, the imem handshake and a one-entry skid.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pc_enable,
  input  logic            busywait_IF_ID,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_pc4,
  output logic [31:0]     if_id_instr,
  output logic            if_id_valid
);
  fetch_state_t    r_state, w_nstate;
  logic [XLEN-1:0] r_pc, r_req_addr, r_skid_pc;
  logic [31:0]     r_skid_instr;
  logic [XLEN-1:0] w_npc, w_nreq, w_tgt, w_req4, w_skid4;
  logic            w_accept, w_load, w_flush, w_skid_ld;
  if_id_t          w_d, w_q;

  assign w_accept = pc_enable & ~busywait_IF_ID;
  assign w_tgt    = {branch_target[XLEN-1:2], 2'b00};
  assign w_req4   = r_req_addr + XLEN'(4);
  assign w_skid4  = r_skid_pc + XLEN'(4);
  assign imem_req  = rst_n & (r_state != HOLD);
  assign imem_addr = r_req_addr;

  always_comb begin
    w_nstate  = r_state;
    w_npc     = r_pc;
    w_nreq    = r_req_addr;
    w_load    = 1'b0;
    w_flush   = 1'b0;
    w_skid_ld = 1'b0;
    w_d       = '{pc: r_req_addr, pc4: w_req4, instr: imem_rdata, valid: 1'b1};
    if (branch_taken) begin
      w_flush = 1'b1;
      w_npc   = w_tgt;
      // An outstanding request must complete at its original address before retargeting.
      case (r_state)
        FETCH:   if (imem_valid) w_nreq = w_tgt; else w_nstate = DISCARD;
        HOLD:    begin w_nreq = w_tgt; w_nstate = FETCH; end
        default: if (imem_valid) begin w_nreq = w_tgt; w_nstate = FETCH; end
      endcase
    end else begin
      case (r_state)
        FETCH: begin
          w_load    = imem_valid & w_accept;
          w_flush   = ~imem_valid & w_accept;
          w_skid_ld = imem_valid & ~w_accept;
          w_npc     = w_load ? w_req4 : r_pc;
          w_nreq    = w_load ? w_req4 : r_req_addr;
          w_nstate  = w_skid_ld ? HOLD : FETCH;
        end
        HOLD: if (w_accept) begin
          w_load   = 1'b1;
          w_d      = '{pc: r_skid_pc, pc4: w_skid4, instr: r_skid_instr, valid: 1'b1};
          w_npc    = w_skid4;
          w_nreq   = w_skid4;
          w_nstate = FETCH;
        end
        default: begin
          w_flush = w_accept;
          if (imem_valid) begin w_nreq = r_pc; w_nstate = FETCH; end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state      <= FETCH;
      r_pc         <= RESET_PC;
      r_req_addr   <= RESET_PC;
      r_skid_pc    <= '0;
      r_skid_instr <= NOP_INSTR;
    end else begin
      r_state    <= w_nstate;
      r_pc       <= w_npc;
      r_req_addr <= w_nreq;
      if (w_skid_ld) begin
        r_skid_pc    <= r_req_addr;
        r_skid_instr <= imem_rdata;
      end
    end

  if_id_reg u_if_id (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (w_load),
    .flush (w_flush),
    .d     (w_d),
    .q     (w_q)
  );

  assign if_id_pc    = w_q.pc;
  assign if_id_pc4   = w_q.pc4;
  assign if_id_instr = w_q.instr;
  assign if_id_valid = w_q.valid;
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
IF stage of the 5-stage RISC-V pipeline. It owns the PC, drives a variable-latency instruction-memory request/response handshake and buffers one response in a skid register. It loads the IF/ID pipeline register consumed by the decode stage and its forwarding/hazard logic. It honours the hazard unit's pc_enable / busywait_IF_ID stall and redirects on taken branches/jumps resolved downstream.

Parameters:
XLEN, 32, datapath and PC width
RESET_PC, 32'h0000_0000, PC value after reset (bits [1:0] must be 0)

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous active-low reset
pc_enable  in  1  hazard unit: 0 = hold PC (load-use stall)
busywait_IF_ID  in  1  hazard unit: 1 = hold IF/ID contents
branch_taken  in  1  redirect request from branch/jump resolution
branch_target  in  XLEN  redirect address; bits [1:0] ignored
imem_req  out  1  instruction fetch request
imem_addr  out  XLEN  fetch address, stable while imem_req=1 until imem_valid
imem_rdata  in  32  instruction word, valid when imem_valid=1
imem_valid  in  1  response strobe; only while imem_req=1, may arrive in the first request cycle
if_id_pc  out  XLEN  PC of instruction in IF/ID
if_id_pc4  out  XLEN  if_id_pc + 4
if_id_instr  out  32  instruction in IF/ID (NOP when invalid)
if_id_valid  out  1  IF/ID holds a real instruction

Behaviour:
- Reset is asynchronous and active-low, clocked on clk. Reset values: pc=RESET_PC, req_addr=RESET_PC, state=FETCH, if_id_pc=0, if_id_pc4=4, if_id_instr=32'h0000_0013 (NOP), if_id_valid=0, skid empty. imem_req is 0 while rst_n=0 and 1 from the first cycle after release.
- accept = pc_enable & ~busywait_IF_ID. IF/ID and PC update only when accept=1, or on redirect.
- FETCH: imem_req=1, imem_addr=req_addr.
  - imem_valid & accept: IF/ID <= {req_addr, rdata, valid=1}; pc, req_addr <= req_addr+4; stay in FETCH. This gives 1 instr/cycle with a zero-wait memory.
  - imem_valid & ~accept: rdata and req_addr go to the skid register; go to HOLD.
  - ~imem_valid & accept: IF/ID <= bubble (NOP, valid=0, pc unchanged).
- HOLD: imem_req=0. On accept: IF/ID <= skid; pc, req_addr <= skid_pc+4; go to FETCH. Otherwise hold.
- DISCARD: imem_req=1 with the stale req_addr, which is kept stable per the handshake. On imem_valid: drop the data and go to FETCH with req_addr <= pc. While waiting, IF/ID <= bubble on accept.
- Redirect (branch_taken=1) overrides any stall. pc <= {branch_target[XLEN-1:2],2'b00}. IF/ID <= NOP with valid=0 regardless of busywait_IF_ID. Next state by current state:
  - FETCH & imem_valid: drop the response; req_addr <= target; stay in FETCH.
  - FETCH & ~imem_valid: go to DISCARD; req_addr unchanged.
  - HOLD: empty the skid; req_addr <= target; go to FETCH.
  - DISCARD & ~imem_valid: stay in DISCARD; pc updated (last redirect wins).
  - DISCARD & imem_valid: go to FETCH with req_addr <= target.
- PC arithmetic is modulo 2^XLEN; 32'hFFFF_FFFC + 4 wraps to 0.
- An instruction is never delivered twice or skipped; the sequence in IF/ID with valid=1 equals program order.

Decomposition:
- riscv_pkg: XLEN, NOP_INSTR = 32'h0000_0013, fetch_state_t enum {FETCH, HOLD, DISCARD}, if_id_t struct {pc, pc4, instr, valid}.
- One sub-module, if_id_reg: the IF/ID register with load/flush/hold controls and async reset to NOP. The FSM, PC and skid stay in the top.

Test Plan:
- Reset release, memory returns on the same cycle, no stalls: IF/ID shows pc 0,4,8,12 on consecutive cycles, valid=1, and if_id_pc4 = pc+4.
- 3-cycle memory latency: imem_addr holds 0 for 3 cycles. if_id_valid=0 bubbles appear, then pc=0 with the correct rdata, then a request to 4.
- busywait_IF_ID=1 and pc_enable=0 for 2 cycles while imem_valid arrives for pc=8: state goes to HOLD, imem_req=0, IF/ID keeps pc=4. After release IF/ID shows pc=8, then a request to 12.
- branch_taken with target 32'h0000_0102 while request pc=16 is outstanding: IF/ID flushes to NOP/valid=0 and the state goes to DISCARD. The stale response for 16 is dropped, then the request goes to 0x100 and IF/ID shows pc=0x100.
- branch_taken together with busywait_IF_ID=1 in HOLD: skid is dropped, IF/ID = NOP, next request to the target.
- rst_n asserted mid-request in DISCARD: all outputs return to reset values asynchronously, and the fetch restarts at RESET_PC.
